fetch_unit: RTL and testbench

Instruction fetch stage of the MIPS core, directly upstream of the control unit. Holds the PC and issues in-order word requests to instruction memory, limiting outstanding requests with a credit counter. Returned words are buffered in a small FIFO and presented with a valid/ready handshake, pre-split into `opcode` and `funct` for the control unit. Handles PC redirects (branches) by flushing buffered words and discarding responses still in flight.

---
 rtl/mips_pkg.sv | 24 ++
 rtl/fetch_fifo.sv | 56 +++++
 rtl/fetch_unit.sv | 121 ++++++++++++
 tb/tb_fetch_unit.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: instruction field positions, word size, reset PC,
// fetch FSM states and the fetch buffer entry layout.
package mips_pkg;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;

    localparam int WORD_BYTES = 4;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: DEPTH entries of {pc, word} with push, pop, clear and occupancy count.
// Latency: a push is visible at the head the cycle after; head outputs come only from state.
// Backpressure: none internally; the producer's credit scheme guarantees no push into a full buffer.
module fetch_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  fetch_entry_t               push_dat_i,
    input  logic                       pop_i,
    input  logic                       clear_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       head_vld_o,
    output fetch_entry_t               head_dat_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t    mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;

    // Clear wins over pop: a head popped in the clearing cycle has already been delivered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_dat_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_i) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign count_o    = count_q;
    assign head_vld_o = (count_q != '0);
    assign head_dat_o = mem_q[rd_ptr_q];

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && !pop_i && !clear_i && count_q == CW'(DEPTH)));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited in-order imem requests, buffered words split into opcode/funct.
// Latency: response in cycle t gives instr_valid in t+1; redirect flushes and drains stale responses.
// Backpressure: instr_ready low holds the buffer; requests stop once outstanding+buffered reach DEPTH.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirect sets sticky fetch_fault and halts fetch.
module fetch_unit
    import mips_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic        fetch_fault
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_e  state_q, state_d;
    logic [31:0]   pc_q, pc_d, redir_pc, resp_pc;
    logic [CW-1:0] out_q, out_d, drop_q, drop_d, occ;
    logic [CW:0]   credit_used;
    logic          fault_q, accept, pop, push, head_vld;
    fetch_entry_t  head, push_dat;

    assign accept = imem_req_valid & imem_req_ready;
    assign pop    = head_vld & instr_ready;
    assign push   = imem_resp_valid & (drop_q == '0) & ~redirect_valid;

    // Live responses are in order and contiguous behind the PC, so the oldest
    // outstanding request's address is the PC minus the outstanding count.
    assign resp_pc  = pc_q - (32'(out_q) * 32'(WORD_BYTES));
    assign push_dat = '{pc: resp_pc, word: imem_resp_data};

    // The entry leaving this cycle frees its slot, which keeps issue at one per cycle.
    assign credit_used = {1'b0, out_q} + {1'b0, occ} - {{CW{1'b0}}, pop};

`ifdef FETCH_ALIGN_CHECK_EN
    assign redir_pc = redirect_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fault_q <= 1'b0;
        else if (redirect_valid && redirect_pc[1:0] != 2'b00) fault_q <= 1'b1;
    end
`else
    logic unused_align;
    assign unused_align = ^redirect_pc[1:0];
    assign redir_pc     = {redirect_pc[31:2], 2'b00};
    assign fault_q      = 1'b0;
`endif

    always_comb begin
        out_d  = out_q + CW'(accept) - CW'(imem_resp_valid);
        drop_d = drop_q;
        if (redirect_valid) drop_d = out_d;
        else if (imem_resp_valid && drop_q != '0) drop_d = drop_q - CW'(1);
        pc_d = pc_q;
        if (redirect_valid) pc_d = redir_pc;
        else if (accept) pc_d = pc_q + 32'(WORD_BYTES);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            out_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            out_q   <= out_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect_valid) state_d = (drop_d != '0) ? DRAIN : RUN;
        else if (state_q == DRAIN && drop_d == '0) state_d = RUN;
    end

    always_comb begin
        imem_req_valid = 1'b0;
        if (rst_n && state_q == RUN && !redirect_valid && !fault_q &&
            credit_used < (CW+1)'(DEPTH))
            imem_req_valid = 1'b1;
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .clear_i    (redirect_valid),
        .count_o    (occ),
        .head_vld_o (head_vld),
        .head_dat_o (head)
    );

    assign imem_req_addr = pc_q;
    assign instr_valid   = head_vld;
    assign instr         = head.word;
    assign instr_pc      = head.pc;
    assign opcode        = head.word[OPCODE_MSB:OPCODE_LSB];
    assign funct         = head.word[FUNCT_MSB:FUNCT_LSB];
    assign fetch_fault   = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order fixed-latency instruction memory model.
module tb_fetch_unit;

    localparam int DEPTH = 2;

    logic        clk, rst_n;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, instr_pc;
    logic [5:0]  opcode, funct;
    logic        fetch_fault;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          lat = 1;
    logic        pipe_v [8];
    logic [31:0] pipe_a [8];
    logic        acc;
    logic [31:0] acc_addr;

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .opcode          (opcode),
        .funct           (funct),
        .fetch_fault     (fetch_fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    // Memory word for an address: opcode = addr[7:2], funct = addr[13:8].
    function automatic logic [31:0] mkword(input logic [31:0] a);
        return {a[7:2], 20'hC0DE0, a[13:8]};
    endfunction

    task automatic half();
        @(negedge clk);
    endtask

    // Record this cycle's accept, advance the clock, drive the response for the new cycle.
    task automatic cyc();
        acc      = imem_req_valid && imem_req_ready;
        acc_addr = imem_req_addr;
        for (int i = 7; i > 0; i--) begin
            pipe_v[i] = pipe_v[i-1];
            pipe_a[i] = pipe_a[i-1];
        end
        pipe_v[0] = acc;
        pipe_a[0] = acc_addr;
        @(posedge clk);
        #1;
        imem_resp_valid = pipe_v[lat-1];
        imem_resp_data  = pipe_v[lat-1] ? mkword(pipe_a[lat-1]) : 32'h0;
    endtask

    task automatic clear_inputs();
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        imem_req_ready  = 1'b1;
        instr_ready     = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        acc             = 1'b0;
        acc_addr        = 32'h0;
        lat             = 1;
        for (int i = 0; i < 8; i++) begin
            pipe_v[i] = 1'b0;
            pipe_a[i] = 32'h0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        clear_inputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        #12;
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rst_req_valid got %b want 0", imem_req_valid); end
        n_cmp++; if (imem_req_addr !== 32'h0) begin n_bad++; $display("FAIL rst_req_addr got %h want 00000000", imem_req_addr); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL rst_instr_valid got %b want 0", instr_valid); end
        n_cmp++; if (instr !== 32'h0) begin n_bad++; $display("FAIL rst_instr got %h want 00000000", instr); end
        n_cmp++; if (instr_pc !== 32'h0) begin n_bad++; $display("FAIL rst_instr_pc got %h want 00000000", instr_pc); end
        n_cmp++; if (fetch_fault !== 1'b0) begin n_bad++; $display("FAIL rst_fault got %b want 0", fetch_fault); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_first_fetch();
        half();
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin n_bad++; $display("FAIL ff_c0_req got %b/%h want 1/00000000", imem_req_valid, imem_req_addr); end
        cyc();
        half();
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin n_bad++; $display("FAIL ff_c1_req got %b/%h want 1/00000004", imem_req_valid, imem_req_addr); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL ff_c1_instr_valid got %b want 0", instr_valid); end
        cyc();
        half();
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin n_bad++; $display("FAIL ff_c2_req got %b/%h want 1/00000008", imem_req_valid, imem_req_addr); end
        n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin n_bad++; $display("FAIL ff_c2_instr got %b/%h want 1/00000000", instr_valid, instr_pc); end
        n_cmp++; if (instr !== mkword(32'h0)) begin n_bad++; $display("FAIL ff_c2_word got %h want %h", instr, mkword(32'h0)); end
        cyc();
        half();
        n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'h4) begin n_bad++; $display("FAIL ff_c3_instr got %b/%h want 1/00000004", instr_valid, instr_pc); end
        n_cmp++; if (opcode !== 6'h01 || funct !== 6'h00) begin n_bad++; $display("FAIL ff_c3_fields got op=%h fn=%h want op=01 fn=00", opcode, funct); end
        cyc();
    endtask

    task automatic test_backpressure();
        int issued = 0;
        int got = 0;
        do_reset();
        instr_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            half();
            cyc();
            if (acc) issued++;
        end
        half();
        n_cmp++; if (issued != DEPTH) begin n_bad++; $display("FAIL bp_issued got %0d want %0d", issued, DEPTH); end
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL bp_req_valid got %b want 0", imem_req_valid); end
        n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin n_bad++; $display("FAIL bp_head got %b/%h want 1/00000000", instr_valid, instr_pc); end
        cyc();
        instr_ready = 1'b1;
        for (int k = 0; k < 12 && got < 3; k++) begin
            half();
            if (instr_valid) begin
                n_cmp++; if (instr_pc !== 32'(got * 4) || instr !== mkword(32'(got * 4))) begin n_bad++; $display("FAIL bp_order%0d got %h/%h want %h/%h", got, instr_pc, instr, 32'(got * 4), mkword(32'(got * 4))); end
                got++;
            end
            cyc();
        end
        n_cmp++; if (got != 3) begin n_bad++; $display("FAIL bp_release got %0d words want 3", got); end
    endtask

    task automatic test_redirect_drain();
        int k;
        do_reset();
        lat = 3;
        half(); cyc();
        half(); cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        half();
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rd_redir_req got %b want 0", imem_req_valid); end
        cyc();
        redirect_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            half();
            n_cmp++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin n_bad++; $display("FAIL rd_drain%0d got req=%b iv=%b want 0/0", c, imem_req_valid, instr_valid); end
            cyc();
        end
        half();
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin n_bad++; $display("FAIL rd_newreq got %b/%h want 1/00000100", imem_req_valid, imem_req_addr); end
        cyc();
        for (k = 0; k < 10; k++) begin
            half();
            if (instr_valid) break;
            cyc();
        end
        n_cmp++; if (k != 3) begin n_bad++; $display("FAIL rd_latency got %0d idle cycles want 3", k); end
        n_cmp++; if (instr_pc !== 32'h100 || instr !== mkword(32'h100)) begin n_bad++; $display("FAIL rd_first got %h/%h want 00000100/%h", instr_pc, instr, mkword(32'h100)); end
        cyc();
    endtask

    task automatic test_redirect_pop_resp();
        int k;
        do_reset();
        half(); cyc();
        half(); cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        half();
        n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin n_bad++; $display("FAIL rp_pop got %b/%h want 1/00000000", instr_valid, instr_pc); end
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rp_req got %b want 0", imem_req_valid); end
        cyc();
        redirect_valid = 1'b0;
        half();
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL rp_empty got %b want 0", instr_valid); end
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin n_bad++; $display("FAIL rp_newreq got %b/%h want 1/00000200", imem_req_valid, imem_req_addr); end
        cyc();
        for (k = 0; k < 10; k++) begin
            half();
            if (instr_valid) break;
            cyc();
        end
        n_cmp++; if (k >= 10 || instr_pc !== 32'h200) begin n_bad++; $display("FAIL rp_next got %h after %0d cycles want 00000200", instr_pc, k); end
        cyc();
    endtask

    task automatic test_wrap();
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        half(); cyc();
        redirect_valid = 1'b0;
        half();
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wr_top got %b/%h want 1/fffffffc", imem_req_valid, imem_req_addr); end
        cyc();
        half();
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin n_bad++; $display("FAIL wr_wrap got %b/%h want 1/00000000", imem_req_valid, imem_req_addr); end
        cyc();
        half();
        n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wr_instr0 got %b/%h want 1/fffffffc", instr_valid, instr_pc); end
        cyc();
        half();
        n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin n_bad++; $display("FAIL wr_instr1 got %b/%h want 1/00000000", instr_valid, instr_pc); end
        cyc();
    endtask

    task automatic test_align();
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        half(); cyc();
        redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        for (int c = 0; c < 3; c++) begin
            half();
            n_cmp++; if (fetch_fault !== 1'b1 || imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL al_fault%0d got fault=%b req=%b want 1/0", c, fetch_fault, imem_req_valid); end
            cyc();
        end
`else
        half();
        n_cmp++; if (fetch_fault !== 1'b0) begin n_bad++; $display("FAIL al_fault got %b want 0", fetch_fault); end
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin n_bad++; $display("FAIL al_req got %b/%h want 1/00000100", imem_req_valid, imem_req_addr); end
        cyc();
        half(); cyc();
        half();
        n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100) begin n_bad++; $display("FAIL al_instr got %b/%h want 1/00000100", instr_valid, instr_pc); end
        cyc();
`endif
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_backpressure();
        test_redirect_drain();
        test_redirect_pop_resp();
        test_wrap();
        test_align();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
